// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the parameterised SPI slave.
//               Holds the FSM state encoding and the bit-order selectors.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Slave FSM: IDLE while deselected, SHIFT while a word may be in flight
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    // Values accepted by the LSB_FIRST parameter
    localparam int c_MSB_FIRST = 0;
    localparam int c_LSB_FIRST = 1;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_fifo
// Description : Receive FIFO for the SPI slave. Power-of-two depth, pointers
//               carry one extra wrap bit. A push into a full FIFO is accepted
//               only when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_not_empty,
    output logic             o_full
);
    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic [c_PTR_W:0] w_count;
    logic             w_not_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_not_empty = (r_wr_ptr != r_rd_ptr);
    assign w_full      = (w_count == c_FULL_CNT);
    assign w_do_pop    = i_pop && w_not_empty;
    // When full, the slot being written is the head slot being freed this edge
    assign w_do_push   = i_push && (!w_full || w_do_pop);

    assign o_not_empty = w_not_empty;
    assign o_full      = w_full;
    assign o_head      = w_not_empty ? r_mem[r_rd_ptr[c_PTR_W-1:0]] : '0;

    // Storage array: written on accepted pushes, never reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_push_data;
        end
    end

    // Read/write pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : spi_rx_fifo
`default_nettype wire

// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_param
// Description : Parameterised SPI slave clocked by sclk. Full-duplex word
//               transfer with registered MISO, tx handshake, receive buffer
//               with overrun detection and sticky underrun/overrun flags.
//               Define SPI_SLAVE_RX_FIFO_EN for an RX_DEPTH-word receive FIFO;
//               otherwise the buffer is a single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RX_DEPTH  = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              select,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              underrun,
    input  logic              clr_flags,
    output logic              busy
);
    localparam int                 c_CNT_W = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

    spi_state_t          r_state;
    spi_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [c_CNT_W-1:0]  w_idx;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [DATA_W-1:0]   r_rx_sr;
    logic [DATA_W-1:0]   w_tx_word;
    logic [DATA_W-1:0]   w_rx_word;
    logic                r_miso;
    logic                r_overrun;
    logic                r_underrun;
    logic                w_word_start;
    logic                w_word_end;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_rx_valid;
    logic [DATA_W-1:0]   w_rx_head;

    assign w_word_start = select && (r_bit_cnt == '0);
    assign w_word_end   = select && (r_bit_cnt == c_LAST);
    assign w_push       = w_word_end;
    assign w_pop        = w_rx_valid && rx_ready;
    // Bit position inside the word addressed by the current bit count
    assign w_idx        = (LSB_FIRST == c_LSB_FIRST) ? r_bit_cnt : (c_LAST - r_bit_cnt);
    // A missing tx word is replaced by zeros
    assign w_tx_word    = tx_valid ? tx_data : '0;

    assign MISO     = r_miso;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;
    assign rx_valid = w_rx_valid;
    assign rx_data  = w_rx_head;

    // Received word including the bit arriving on this edge
    always_comb begin
        w_rx_word        = r_rx_sr;
        w_rx_word[w_idx] = MOSI;
    end

    // FSM state register
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        tx_ready    = (r_bit_cnt == '0);
        case (r_state)
            IDLE: begin
                if (select) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = (r_bit_cnt != '0);
                if (!select) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bit counter, shift registers and MISO; deselect abandons the word
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_miso    <= 1'b0;
        end else if (select) begin
            r_bit_cnt <= (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + 1'b1;
            r_rx_sr   <= w_rx_word;
            if (w_word_start) begin
                r_tx_sr <= w_tx_word;
                r_miso  <= w_tx_word[w_idx];
            end else begin
                r_miso  <= r_tx_sr[w_idx];
            end
        end else begin
            r_bit_cnt <= '0;
            r_rx_sr   <= '0;
            r_miso    <= 1'b0;
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_word_start && !tx_valid) begin
                r_underrun <= 1'b1;
            end else if (clr_flags) begin
                r_underrun <= 1'b0;
            end
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else if (clr_flags) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    spi_rx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk         (sclk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_rx_word),
        .i_pop       (w_pop),
        .o_head      (w_rx_head),
        .o_not_empty (w_rx_valid),
        .o_full      (w_full)
    );
`else
    // Single-entry buffer; the configured depth has no effect here
    localparam int c_HOLD_DEPTH = (RX_DEPTH > 0) ? 1 : 1;

    logic              r_hold_valid;
    logic [DATA_W-1:0] r_hold_data;

    assign w_rx_valid = r_hold_valid;
    assign w_full     = r_hold_valid && (c_HOLD_DEPTH == 1);
    assign w_rx_head  = r_hold_valid ? r_hold_data : '0;

    // Holding register: a push is accepted if empty or popped on the same edge
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_push && (!w_full || w_pop)) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= w_rx_word;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

endmodule : spi_slave_param
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_param
// Description : Self-checking bench for spi_slave_param. An MSB-first and an
//               LSB-first instance share all inputs; a word-level reference
//               model tracks expected MISO, receive queues and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       select = 1'b0;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic       clr_flags = 1'b0;

    logic       miso, tx_ready, rx_valid, overrun, underrun, busy;
    logic [7:0] rx_data;
    logic       l_miso, l_tx_ready, l_rx_valid, l_overrun, l_underrun, l_busy;
    logic [7:0] l_rx_data;

    spi_slave_param #(.DATA_W(8), .RX_DEPTH(4), .LSB_FIRST(0)) dut (
        .sclk(sclk), .rst_n(rst_n), .select(select), .MOSI(mosi), .MISO(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overrun(overrun), .underrun(underrun), .clr_flags(clr_flags), .busy(busy)
    );

    spi_slave_param #(.DATA_W(8), .RX_DEPTH(4), .LSB_FIRST(1)) dut_l (
        .sclk(sclk), .rst_n(rst_n), .select(select), .MOSI(mosi), .MISO(l_miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(l_tx_ready),
        .rx_data(l_rx_data), .rx_valid(l_rx_valid), .rx_ready(rx_ready),
        .overrun(l_overrun), .underrun(l_underrun), .clr_flags(clr_flags), .busy(l_busy)
    );

    always #5 sclk = ~sclk;

    // Reference model state
    int         m_pos;
    logic [7:0] m_word;
    logic       m_bits [8];
    logic       m_miso, m_lmiso, m_ovr, m_udr;
    logic [7:0] m_q[$];
    logic [7:0] m_lq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        m_pos = 0; m_word = 8'h00; m_miso = 1'b0; m_lmiso = 1'b0;
        m_ovr = 1'b0; m_udr = 1'b0;
        m_q.delete(); m_lq.delete();
    endtask

    // One sclk rising edge: drive inputs at negedge, update the model at posedge
    task automatic step(input logic sel, input logic bit_in, input logic [7:0] txd,
                        input logic txv, input logic rdy, input logic clr);
        logic pop, udr_evt, ovr_evt, do_push;
        logic [7:0] wm, wl;
        int sz;
        @(negedge sclk);
        select = sel; mosi = bit_in; tx_data = txd; tx_valid = txv;
        rx_ready = rdy; clr_flags = clr;
        @(posedge sclk);
        sz = m_q.size();
        pop = rdy && (sz > 0);
        udr_evt = 1'b0; ovr_evt = 1'b0; do_push = 1'b0; wm = 8'h00; wl = 8'h00;
        if (sel) begin
            if (m_pos == 0) begin
                m_word  = txv ? txd : 8'h00;
                udr_evt = !txv;
            end
            m_miso  = m_word[7 - m_pos];
            m_lmiso = m_word[m_pos];
            m_bits[m_pos] = bit_in;
            if (m_pos == 7) begin
                for (int k = 0; k < 8; k++) begin
                    wm[7 - k] = m_bits[k];
                    wl[k]     = m_bits[k];
                end
                if (sz < DEPTH || pop) do_push = 1'b1;
                else                   ovr_evt = 1'b1;
            end
            m_pos = (m_pos + 1) % 8;
        end else begin
            m_pos = 0; m_miso = 1'b0; m_lmiso = 1'b0;
        end
        if (pop) begin
            void'(m_q.pop_front());
            void'(m_lq.pop_front());
        end
        if (do_push) begin
            m_q.push_back(wm);
            m_lq.push_back(wl);
        end
        m_ovr = ovr_evt || (m_ovr && !clr);
        m_udr = udr_evt || (m_udr && !clr);
        #1;
    endtask

    task automatic send_word(input logic [7:0] txd, input logic txv,
                             input logic [7:0] mosi_w, input logic rdy);
        for (int k = 0; k < 8; k++) step(1'b1, mosi_w[7 - k], txd, txv, rdy, 1'b0);
    endtask

    task automatic hw_reset();
        select = 1'b0; mosi = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0; clr_flags = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        @(negedge sclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (miso !== 1'b0)     begin n_fail++; $display("FAIL reset_miso got %b exp 0", miso); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        n_tests++; if (overrun !== 1'b0)  begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b exp 0", underrun); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
        model_reset();
        @(negedge sclk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_word();
        logic [7:0] exp_tx, mw;
        exp_tx = 8'hA5; mw = 8'h3C;
        hw_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, mw[7 - k], 8'hA5, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (miso !== exp_tx[7 - k]) begin n_fail++; $display("FAIL basic_miso edge %0d got %b exp %b", k + 1, miso, exp_tx[7 - k]); end
            if (k == 3) begin
                n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
                n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_tx_ready got %b exp 0", tx_ready); end
            end
        end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rx_valid got %b exp 1", rx_valid); end
        n_tests++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL basic_rx_data got %h exp 3c", rx_data); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop got %b exp 0", rx_valid); end
        n_tests++; if (miso !== 1'b0)     begin n_fail++; $display("FAIL basic_idle_miso got %b exp 0", miso); end
    endtask

    task automatic test_overrun();
        hw_reset();
        for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b1, 8'(w), 1'b0);
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++; if (rx_valid !== 1'b1)    begin n_fail++; $display("FAIL ovr_valid %0d got %b exp 1", i, rx_valid); end
            n_tests++; if (rx_data !== 8'(i + 1)) begin n_fail++; $display("FAIL ovr_order %0d got %h exp %h", i, rx_data, 8'(i + 1)); end
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained got %b exp 0", rx_valid); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_tests++; if (overrun !== 1'b0)  begin n_fail++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mw;
        hw_reset();
        for (int i = 0; i < DEPTH; i++) send_word(8'h00, 1'b1, 8'h10 + 8'(i), 1'b0);
        mw = 8'hEE;
        // Full buffer; pop lands on the same edge as the final push
        for (int k = 0; k < 8; k++) step(1'b1, mw[7 - k], 8'h00, 1'b1, (k == 7), 1'b0);
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun got %b exp 0", overrun); end
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (rx_data !== m_q[0]) begin n_fail++; $display("FAIL b2b_order %0d got %h exp %h", i, rx_data, m_q[0]); end
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %b exp 0", rx_valid); end
    endtask

    task automatic test_abort();
        hw_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
        n_tests++; if (miso !== 1'b0)     begin n_fail++; $display("FAIL abort_miso got %b exp 0", miso); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_tx_ready got %b exp 1", tx_ready); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rx_valid got %b exp 0", rx_valid); end
        send_word(8'h11, 1'b1, 8'h7E, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_tests++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL abort_rx_data got %h exp 7e", rx_data); end
        n_tests++; if (underrun !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL abort_flags got %b%b exp 00", overrun, underrun); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_single got %b exp 0", rx_valid); end
    endtask

    task automatic test_underrun();
        hw_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
            n_tests++; if (miso !== 1'b0) begin n_fail++; $display("FAIL udr_miso edge %0d got %b exp 0", k + 1, miso); end
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL udr_flag got %b exp 1", underrun); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL udr_clear got %b exp 0", underrun); end
        step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL udr_set_wins got %b exp 1", underrun); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL udr_partial_push got %b exp 0", rx_valid); end
    endtask

    task automatic test_lsb_first();
        hw_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), 8'h01, 1'b1, 1'b0, 1'b0);
            n_tests++; if (l_miso !== (k == 0)) begin n_fail++; $display("FAIL lsb_miso edge %0d got %b exp %b", k + 1, l_miso, (k == 0)); end
        end
        n_tests++; if (l_rx_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_rx_valid got %b exp 1", l_rx_valid); end
        n_tests++; if (l_rx_data !== 8'h01) begin n_fail++; $display("FAIL lsb_rx_data got %h exp 01", l_rx_data); end
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midword();
        hw_reset();
        send_word(8'h00, 1'b0, 8'h5A, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        n_tests++; if (miso !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got miso %b busy %b exp 1 1", miso, busy); end
        rst_n = 1'b0; select = 1'b0;
        model_reset();
        #1;
        n_tests++; if (miso !== 1'b0)     begin n_fail++; $display("FAIL rstmid_miso got %b exp 0", miso); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid got %b exp 0", rx_valid); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data got %h exp 00", rx_data); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_underrun got %b exp 0", underrun); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready got %b exp 1", tx_ready); end
        @(negedge sclk);
        rst_n = 1'b1;
        send_word(8'h96, 1'b1, 8'hC3, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_tests++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin n_fail++; $display("FAIL rstmid_next got %b/%h exp 1/c3", rx_valid, rx_data); end
    endtask

    task automatic test_random();
        logic [7:0] e_d, e_ld;
        logic       e_v;
        hw_reset();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 29) == 0));
            e_v  = (m_q.size() != 0);
            e_d  = e_v ? m_q[0]  : 8'h00;
            e_ld = e_v ? m_lq[0] : 8'h00;
            n_tests++; if (miso !== m_miso)      begin n_fail++; $display("FAIL rnd_miso %0d got %b exp %b", n, miso, m_miso); end
            n_tests++; if (l_miso !== m_lmiso)   begin n_fail++; $display("FAIL rnd_lmiso %0d got %b exp %b", n, l_miso, m_lmiso); end
            n_tests++; if (rx_valid !== e_v)     begin n_fail++; $display("FAIL rnd_rx_valid %0d got %b exp %b", n, rx_valid, e_v); end
            n_tests++; if (rx_data !== e_d)      begin n_fail++; $display("FAIL rnd_rx_data %0d got %h exp %h", n, rx_data, e_d); end
            n_tests++; if (l_rx_data !== e_ld)   begin n_fail++; $display("FAIL rnd_lrx_data %0d got %h exp %h", n, l_rx_data, e_ld); end
            n_tests++; if (overrun !== m_ovr)    begin n_fail++; $display("FAIL rnd_overrun %0d got %b exp %b", n, overrun, m_ovr); end
            n_tests++; if (underrun !== m_udr)   begin n_fail++; $display("FAIL rnd_underrun %0d got %b exp %b", n, underrun, m_udr); end
            n_tests++; if (busy !== (m_pos != 0)) begin n_fail++; $display("FAIL rnd_busy %0d got %b exp %b", n, busy, (m_pos != 0)); end
            n_tests++; if (tx_ready !== (m_pos == 0)) begin n_fail++; $display("FAIL rnd_tx_ready %0d got %b exp %b", n, tx_ready, (m_pos == 0)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_word();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_underrun();
        test_lsb_first();
        test_reset_midword();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule : tb_spi_slave_param
`default_nettype wire
